out_mem_bank: RTL and testbench
===============================

# out_mem_bank

Parametrised output buffer for convolution-layer results: a DEPTH-word memory whose words hold LANES lanes of DW bits. Each lane is individually writable and can be overwritten or saturating-accumulated for partial sums. The bank supports single-word random reads, a hardware clear sequence, and a valid/ready streaming drain. It replaces the per-filter output memory and its file dump with a synthesizable store that sits between the PE array and the downstream write-back stage.

## Interface
- LANES, 4, lanes per word
- DW, 8, bits per lane
- DEPTH, 128, words in the bank
- AW, $clog2(DEPTH), address width (derived)
- LW, $clog2(LANES), lane-index width (derived)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  lane write request
- wr_acc  in  1  1 = saturating add into lane, 0 = overwrite
- wr_addr  in  AW  write word address
- wr_lane  in  LW  write lane; lane 0 = MSB lane of the word
- wr_data  in  DW  write data
- rd_en  in  1  word read request
- rd_addr  in  AW  read word address
- rd_data  out  LANES*DW  registered read word
- rd_valid  out  1  rd_data valid, one-cycle pulse
- clr_start  in  1  zero the whole bank
- drain_start  in  1  begin streaming drain
- drain_base  in  AW  first drain address
- drain_len  in  AW+1  words to drain, 1..DEPTH
- drain_data  out  LANES*DW  streamed word
- drain_valid  out  1  drain_data valid
- drain_ready  in  1  consumer accepts
- drain_last  out  1  marks the final drained word
- busy  out  1  high while in CLEAR or DRAIN

## Operation
- Lane k occupies word bits [(LANES-k)*DW-1 -: DW].
- FSM states:
  - IDLE: accepts clr_start and drain_start, and services wr_en and rd_en.
  - CLEAR: a counter zeroes one word per cycle from 0 to DEPTH-1, then the FSM returns to IDLE.
  - DRAIN: streams drain_len words from drain_base, then returns to IDLE.
- Start requests:
  - clr_start and drain_start in the same IDLE cycle: clear wins and the drain request is dropped.
  - drain_start with drain_len = 0 is ignored.
  - drain_len values above DEPTH are clamped to DEPTH.
  - Start requests while busy are ignored.
- Writes:
  - Overwrite (wr_acc = 0): lane ← wr_data.
  - Accumulate (wr_acc = 1): lane ← min(lane + wr_data, 2^DW-1), unsigned. The read-modify-write completes in one cycle.
- Reads: rd_en loads rd_data from mem[rd_addr] at the clock edge.
- Same-cycle write and read to the same address: the read returns the pre-write word.
- While busy, wr_en and rd_en are ignored; rd_valid stays 0.
- Drain:
  - Addresses run base, base+1, … modulo DEPTH, so wrap-around is legal.
  - While drain_valid=1 and drain_ready=0, drain_data and drain_last hold stable.
  - A word transfers on the edge where drain_valid and drain_ready are both 1.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - rd_data, rd_valid, drain_data, drain_valid, drain_last and busy are all 0.
  - Memory contents are not reset.
- Reset asserted mid-CLEAR or mid-DRAIN aborts the operation immediately. drain_valid and busy drop asynchronously.
- Write: takes effect at the edge where wr_en is sampled and is visible to a read issued on the next cycle.
- Read: 1-cycle latency. rd_valid pulses in the cycle after rd_en; rd_data holds until the next read.
- Clear:
  - busy rises the cycle after clr_start and stays high exactly DEPTH cycles.
  - Writes are accepted again on the cycle busy falls.
- Drain:
  - busy and drain_valid rise the cycle after drain_start, with the word at drain_base.
  - With drain_ready held high, one word transfers per cycle.
  - drain_last=1 accompanies word drain_len-1.
  - busy and drain_valid fall the cycle after the last transfer.

## Structure
- Package out_mem_pkg holds:
  - the state enum (IDLE, CLEAR, DRAIN);
  - the lane-slice index function;
  - the saturation-limit constant helper.
- Sub-module out_mem_sat_add (DW-parameterised unsigned saturating adder) is used in the accumulate path.
- The memory is a register array inside out_mem_bank.

## Test plan
- Reset, then clear (LANES=4, DW=8): after reset, assert clr_start → busy high 128 cycles; reads of addr 0, 64 and 127 return 0x00000000.
- Lane write: overwrite addr 5 lane 0 with 0xAB and lane 3 with 0x12, then read addr 5 → rd_data=0xAB000012 one cycle later, rd_valid one pulse.
- Saturating accumulate: accumulate 0xF0 then 0x20 into addr 9 lane 1 → lane 1 reads 0xFF. Accumulate 0x03 into 0x04 → 0x07.
- Same-cycle hazard: addr 2 holds 0x11111111; overwrite lane 2 with 0x55 while reading addr 2 → rd_data=0x11111111, and the next read gives 0x11115511.
- Drain with wrap and backpressure: drain_base=126, drain_len=4, drain_ready toggling 1,0,1,1,0,1 → words from 126, 127, 0, 1 in order, each held during stalls; drain_last on word 4 only; busy falls the cycle after the last accept.
- Priority and abort:
  - clr_start and drain_start in the same cycle → only CLEAR runs.
  - Reset asserted at drain word 2 → drain_valid=0 immediately and state IDLE.
  - A new drain_start afterwards works normally.

Source files
------------

// File: rtl/out_mem_pkg.sv
// rtl/out_mem_pkg.sv - shared state type and lane/saturation helpers for the output bank
package out_mem_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  // Lane 0 lives in the most significant slice of a word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lanes,
                                           input int unsigned dw);
    return (lanes - 1 - lane) * dw;
  endfunction

  function automatic longint unsigned sat_limit(input int unsigned dw);
    return (64'd1 << dw) - 64'd1;
  endfunction

endpackage

// File: rtl/out_mem_sat_add.sv
// rtl/out_mem_sat_add.sv - unsigned saturating adder for partial-sum accumulation
module out_mem_sat_add #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum
);
  import out_mem_pkg::*;

  localparam logic [DW-1:0] LIMIT = DW'(sat_limit(DW));

  logic [DW:0] wide;

  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    sum  = wide[DW] ? LIMIT : wide[DW-1:0];
  end

endmodule

// File: rtl/out_mem_bank.sv
// rtl/out_mem_bank.sv - lane-writable output bank with accumulate, clear sequencer and stream drain
module out_mem_bank #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(LANES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                wr_acc,
  input  logic [AW-1:0]       wr_addr,
  input  logic [LW-1:0]       wr_lane,
  input  logic [DW-1:0]       wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [LANES*DW-1:0] rd_data,
  output logic                rd_valid,
  input  logic                clr_start,
  input  logic                drain_start,
  input  logic [AW-1:0]       drain_base,
  input  logic [AW:0]         drain_len,
  output logic [LANES*DW-1:0] drain_data,
  output logic                drain_valid,
  input  logic                drain_ready,
  output logic                drain_last,
  output logic                busy
);
  import out_mem_pkg::*;

  localparam int              WW        = LANES * DW;
  localparam int              OW        = $clog2(WW);
  localparam logic [AW:0]     DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  logic [WW-1:0] mem [DEPTH];

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] drain_addr;
  logic [AW:0]   drain_idx;
  logic [AW:0]   drain_len_q;

  logic [OW-1:0] lane_off;
  logic [DW-1:0] old_lane;
  logic [DW-1:0] acc_lane;
  logic [DW-1:0] new_lane;
  logic [AW:0]   len_c;
  logic [AW-1:0] next_addr;
  logic [AW:0]   next_idx;

  always_comb begin
    lane_off  = OW'(lane_lsb(32'(wr_lane), LANES, DW));
    old_lane  = mem[wr_addr][lane_off +: DW];
    new_lane  = wr_acc ? acc_lane : wr_data;
    len_c     = (drain_len > DEPTH_W) ? DEPTH_W : drain_len;
    next_addr = (drain_addr == LAST_ADDR) ? '0 : drain_addr + AW'(1);
    next_idx  = drain_idx + (AW+1)'(1);
  end

  out_mem_sat_add #(.DW(DW)) u_sat (
    .a   (old_lane),
    .b   (wr_data),
    .sum (acc_lane)
  );

  // Storage is not reset; writes are gated off while reset is held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_cnt] <= '0;
      else if (state == IDLE && wr_en)
        mem[wr_addr][lane_off +: DW] <= new_lane;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      drain_addr  <= '0;
      drain_idx   <= '0;
      drain_len_q <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      drain_data  <= '0;
      drain_valid <= 1'b0;
      drain_last  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_en) begin
            rd_data  <= mem[rd_addr];
            rd_valid <= 1'b1;
          end
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end else if (drain_start && drain_len != '0) begin
            state       <= DRAIN;
            busy        <= 1'b1;
            drain_valid <= 1'b1;
            drain_addr  <= drain_base;
            drain_idx   <= '0;
            drain_len_q <= len_c;
            drain_data  <= mem[drain_base];
            drain_last  <= (len_c == (AW+1)'(1));
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        DRAIN: begin
          // Word and last flag only advance on an accepted transfer, so stalls hold them.
          if (drain_ready) begin
            if (drain_last) begin
              state       <= IDLE;
              busy        <= 1'b0;
              drain_valid <= 1'b0;
              drain_last  <= 1'b0;
            end else begin
              drain_addr <= next_addr;
              drain_idx  <= next_idx;
              drain_data <= mem[next_addr];
              drain_last <= (next_idx == drain_len_q - (AW+1)'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_mem_bank.sv
// tb/tb_out_mem_bank.sv - table-driven and scoreboarded bench for out_mem_bank
module tb_out_mem_bank;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int LW    = 2;
  localparam int WW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0, wr_acc = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [LW-1:0] wr_lane = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          clr_start = 1'b0, drain_start = 1'b0;
  logic [AW-1:0] drain_base = '0;
  logic [AW:0]   drain_len = '0;
  logic [WW-1:0] drain_data;
  logic          drain_valid, drain_ready = 1'b0, drain_last, busy;

  out_mem_bank #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .drain_start(drain_start), .drain_base(drain_base),
    .drain_len(drain_len), .drain_data(drain_data), .drain_valid(drain_valid),
    .drain_ready(drain_ready), .drain_last(drain_last), .busy(busy)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
  } dexp_t;

  typedef struct {
    logic          we;
    logic          acc;
    logic [AW-1:0] wa;
    logic [LW-1:0] wl;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [WW-1:0] exp;
  } vec_t;

  logic [WW-1:0] rd_q[$];
  dexp_t         drain_q[$];
  logic [WW-1:0] model[DEPTH];
  vec_t          tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t v(input logic we, input logic acc, input logic [AW-1:0] wa,
                             input logic [LW-1:0] wl, input logic [DW-1:0] wd,
                             input logic re, input logic [AW-1:0] ra, input logic [WW-1:0] e);
    vec_t r;
    r.we = we; r.acc = acc; r.wa = wa; r.wl = wl; r.wd = wd; r.re = re; r.ra = ra; r.exp = e;
    return r;
  endfunction

  function automatic logic [WW-1:0] mk_word(input logic [AW-1:0] a);
    logic [7:0] b;
    b = {1'b0, a};
    return {b, ~b, 8'h5A, b + 8'h31};
  endfunction

  task automatic model_wr(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [DW-1:0] d, input logic acc);
    int         sh;
    logic [8:0] s;
    logic [7:0] nb;
    sh = (LANES - 1 - int'(l)) * DW;
    s  = {1'b0, 8'(model[a] >> sh)} + {1'b0, d};
    nb = acc ? (s[8] ? 8'hFF : s[7:0]) : d;
    model[a] = (model[a] & ~(32'hFF << sh)) | (32'(nb) << sh);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [LW-1:0] l,
                    input logic [DW-1:0] d, input logic acc);
    wr_en = 1'b1; wr_acc = acc; wr_addr = a; wr_lane = l; wr_data = d;
    model_wr(a, l, d, acc);
    @(posedge clock); #1;
    wr_en = 1'b0; wr_acc = 1'b0;
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [WW-1:0] w);
    for (int l = 0; l < LANES; l++)
      wr(a, LW'(l), 8'(w >> (8 * (LANES - 1 - l))), 1'b0);
  endtask

  // Clear run; requests issued while busy must all be ignored.
  task automatic run_clear(input logic with_drain);
    int   cnt;
    logic dv_seen;
    drain_ready = 1'b1; drain_base = '0; drain_len = 8'd4;
    clr_start = 1'b1; drain_start = with_drain;
    @(posedge clock); #1;
    clr_start = 1'b0; drain_start = 1'b1;
    wr_en = 1'b1; wr_acc = 1'b0; wr_addr = 7'd64; wr_lane = 2'd0; wr_data = 8'h77;
    rd_en = 1'b1; rd_addr = 7'd0;
    check("clr_busy_rise", busy, 1);
    cnt = 0; dv_seen = 1'b0;
    while (busy && cnt < 1000) begin
      dv_seen |= drain_valid;
      cnt++;
      @(posedge clock); #1;
    end
    drain_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0; drain_ready = 1'b0;
    check("clr_busy_cycles", cnt, DEPTH);
    check("clr_no_drain", dv_seen, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic start_drain(input logic [AW-1:0] base, input logic [AW:0] len);
    drain_base = base; drain_len = len; drain_start = 1'b1;
    @(posedge clock); #1;
    drain_start = 1'b0;
  endtask

  always @(negedge clock) begin
    dexp_t d;
    if (!reset && rd_valid) begin
      if (rd_q.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
      else check("rd_data", rd_data, rd_q.pop_front());
    end
    if (!reset && drain_valid && drain_ready) begin
      if (drain_q.size() == 0) check("drain_unexpected", drain_valid, 0);
      else begin
        d = drain_q.pop_front();
        check("drain_data", drain_data, d.data);
        check("drain_last", drain_last, d.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int            pat[6] = '{1, 0, 1, 1, 0, 1};
    logic [WW-1:0] prev_data;
    logic          prev_last;
    int            cnt;

    #1;
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_drain_data", drain_data, 0);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_drain_last", drain_last, 0);
    check("rst_busy", busy, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    wr(7'd0, 2'd0, 8'hC3, 1'b0);
    wr(7'd64, 2'd1, 8'h3C, 1'b0);
    wr(7'd127, 2'd3, 8'h99, 1'b0);
    run_clear(1'b0);

    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd0,   32'h00000000));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd64,  32'h00000000));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd127, 32'h00000000));
    tbl.push_back(v(1, 0, 7'd5,  2'd0, 8'hAB, 0, 7'd0,   32'h0));
    tbl.push_back(v(1, 0, 7'd5,  2'd3, 8'h12, 0, 7'd0,   32'h0));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd5,   32'hAB000012));
    tbl.push_back(v(1, 1, 7'd9,  2'd1, 8'hF0, 0, 7'd0,   32'h0));
    tbl.push_back(v(1, 1, 7'd9,  2'd1, 8'h20, 0, 7'd0,   32'h0));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd9,   32'h00FF0000));
    tbl.push_back(v(1, 1, 7'd10, 2'd2, 8'h04, 0, 7'd0,   32'h0));
    tbl.push_back(v(1, 1, 7'd10, 2'd2, 8'h03, 0, 7'd0,   32'h0));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd10,  32'h00000700));
    tbl.push_back(v(1, 0, 7'd2,  2'd0, 8'h11, 0, 7'd0,   32'h0));
    tbl.push_back(v(1, 0, 7'd2,  2'd1, 8'h11, 0, 7'd0,   32'h0));
    tbl.push_back(v(1, 0, 7'd2,  2'd2, 8'h11, 0, 7'd0,   32'h0));
    tbl.push_back(v(1, 0, 7'd2,  2'd3, 8'h11, 0, 7'd0,   32'h0));
    tbl.push_back(v(1, 0, 7'd2,  2'd2, 8'h55, 1, 7'd2,   32'h11111111));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd2,   32'h11115511));
    tbl.push_back(v(1, 1, 7'd9,  2'd1, 8'h01, 1, 7'd9,   32'h00FF0000));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd9,   32'h00FF0000));
    tbl.push_back(v(1, 1, 7'd5,  2'd0, 8'h54, 0, 7'd0,   32'h0));
    tbl.push_back(v(0, 0, 7'd0,  2'd0, 8'h00, 1, 7'd5,   32'hFF000012));

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_acc = tbl[i].acc; wr_addr = tbl[i].wa;
      wr_lane = tbl[i].wl; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      if (tbl[i].we) model_wr(tbl[i].wa, tbl[i].wl, tbl[i].wd, tbl[i].acc);
      if (tbl[i].re) rd_q.push_back(tbl[i].exp);
      @(posedge clock); #1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    check("rd_q_empty", rd_q.size(), 0);

    // Wrapping drain with backpressure.
    wr_word(7'd126, mk_word(7'd126));
    wr_word(7'd127, mk_word(7'd127));
    wr_word(7'd0, mk_word(7'd0));
    wr_word(7'd1, mk_word(7'd1));
    for (int i = 0; i < 4; i++) drain_q.push_back('{mk_word(AW'(126 + i)), i == 3});
    start_drain(7'd126, 8'd4);
    check("drain_busy_rise", busy, 1);
    check("drain_valid_rise", drain_valid, 1);
    prev_data = drain_data; prev_last = drain_last;
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && pat[i-1] == 0) begin
        check("stall_hold_data", drain_data, prev_data);
        check("stall_hold_last", drain_last, prev_last);
        check("stall_valid", drain_valid, 1);
      end
      prev_data = drain_data; prev_last = drain_last;
      drain_ready = (pat[i] != 0);
      @(posedge clock); #1;
    end
    check("drain_busy_fall", busy, 0);
    check("drain_valid_fall", drain_valid, 0);
    check("drain_q_empty", drain_q.size(), 0);
    drain_ready = 1'b0;

    run_clear(1'b1);

    // Reset while word 2 of a drain is presented.
    for (int a = 0; a < 4; a++) wr_word(AW'(a), mk_word(AW'(a)));
    drain_ready = 1'b1;
    for (int i = 0; i < 4; i++) drain_q.push_back('{mk_word(AW'(i)), i == 3});
    start_drain(7'd0, 8'd4);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_word2", drain_data, mk_word(7'd2));
    reset = 1'b1;
    #1;
    check("abort_valid", drain_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_q_left", drain_q.size(), 2);
    drain_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    rd_en = 1'b1; rd_addr = 7'd1; rd_q.push_back(mk_word(7'd1));
    @(posedge clock); #1;
    rd_en = 1'b0;
    @(posedge clock); #1;
    check("abort_idle_read", rd_q.size(), 0);

    drain_q.push_back('{mk_word(7'd1), 1'b0});
    drain_q.push_back('{mk_word(7'd2), 1'b1});
    start_drain(7'd1, 8'd2);
    cnt = 0;
    while (busy && cnt < 10) begin cnt++; @(posedge clock); #1; end
    check("redrain_cycles", cnt, 2);
    check("redrain_q_empty", drain_q.size(), 0);

    start_drain(7'd3, 8'd0);
    check("len0_busy", busy, 0);
    check("len0_valid", drain_valid, 0);

    for (int i = 0; i < DEPTH; i++) drain_q.push_back('{model[i], i == DEPTH - 1});
    start_drain(7'd0, 8'd200);
    cnt = 0;
    while (busy && cnt < 300) begin cnt++; @(posedge clock); #1; end
    check("clamp_cycles", cnt, DEPTH);
    check("clamp_q_empty", drain_q.size(), 0);
    drain_ready = 1'b0;

    @(posedge clock); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
